// File: rtl/seq_multiplier_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock.
// Optional macro SEQ_MULTIPLIER_ZERO_SKIP_EN short-cuts zero operands straight to DONE.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier_next;

  // One iteration: add into the upper half with carry, then shift {carry, acc, mplier} right.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    addend      = mplier[0] ? mcand : '0;
    sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_next    = {sum, acc[WIDTH-1:1]};
    mplier_next = {acc[0], mplier[WIDTH-1:1]};
  end

  // NOTE: all state, including the operand and accumulator registers, is cleared by reset
  // so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      done <= 1'b0;
      case (state)
        // The DONE->IDLE edge also samples start, giving a WIDTH+1 initiation interval.
        IDLE, DONE: begin
          if (start) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
            if (multiplicand == '0 || multiplier == '0) begin
              state   <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              product <= '0;
            end else begin
              state <= BUSY;
              busy  <= 1'b1;
            end
`else
            state <= BUSY;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            product <= acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier with a product scoreboard queue.
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int t0         = 0;
  int t_done     = 0;

  logic [2*W-1:0] sb[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one start pulse; returns just after the accepting edge E0.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input bit hold);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    if (push) sb.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
    @(posedge clk);
    #1;
    t0 = cyc;
    if (!hold) start = 1'b0;
  endtask

  // Waits for done, checks latency (edges after E0), product, busy and pulse width.
  task automatic wait_done(input string tag, input int exp_lat, output logic [2*W-1:0] got);
    int n;
    logic [2*W-1:0] exp_p;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      check({tag, "_busy"}, busy, 1);
      @(posedge clk);
      #1;
      n++;
    end
    got = product;
    if (done !== 1'b1) begin
      check({tag, "_timeout"}, done, 1);
    end else begin
      t_done = cyc;
      check({tag, "_lat"}, cyc - t0, exp_lat);
    end
    exp_p = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, "_product"}, product, exp_p);
    check({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    logic [2*W-1:0] p;
    logic [2*W-1:0] p2;
    int first_done;
    int extra;
    int zero_lat;

`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
    zero_lat = 0;
`else
    zero_lat = W;
`endif

    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_start(4'd7, 4'd9, 1, 0);
    wait_done("m7x9", W, p);

    do_start(4'd15, 4'd15, 1, 0);
    wait_done("m15x15", W, p);

    do_start(4'd1, 4'd15, 1, 0);
    wait_done("m1x15", W, p);

    do_start(4'd0, 4'd13, 1, 0);
    wait_done("m0x13", zero_lat, p);

    // Start re-asserted with 3x3 while 5x6 is busy; it must be ignored.
    do_start(4'd5, 4'd6, 1, 0);
    multiplicand = 4'd3;
    multiplier   = 4'd3;
    start        = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("m5x6", W, p);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    check("m5x6_no_second_op", extra, 0);

    // Asynchronous reset in the second BUSY cycle of 11x12.
    do_start(4'd11, 4'd12, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_start(4'd2, 4'd8, 1, 0);
    wait_done("m2x8", W, p);

    // Back-to-back with start held: 6x5 accepted at E0, 4x4 at the DONE edge.
    do_start(4'd6, 4'd5, 1, 1);
    multiplicand = 4'd4;
    multiplier   = 4'd4;
    sb.push_back(8'd16);
    wait_done("b2b_a", W, p);
    first_done = t_done;
    start = 1'b0;
    t0 = cyc;
    wait_done("b2b_b", W, p2);
    check("b2b_done_gap", t_done - first_done, W + 1);
    check("b2b_a_div", p / 8'd6, 5);
    check("b2b_b_div", p2 / 8'd4, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
